// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W      = 4;

  localparam logic [15:0] BYTE_MASK = 16'h00FF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port RAM: synchronous write with low-byte lane enable, combinational read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              byte_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] wmask;

  // Byte writes merge into the existing word so the upper byte survives.
  assign wmask = byte_i ? DATA_W'(BYTE_MASK) : '1;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= (mem_q[idx_i] & ~wmask) | (wdata_i & wmask);
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for MEM-stage loads/stores with programmable wait states.
// Optional MEM_FAULT_EN: out-of-range accesses fault instead of wrapping.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              fault
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              mem_we;
  logic              acc_ok;
  logic [DATA_W-1:0] mem_rd;

`ifdef MEM_FAULT_EN
  assign acc_ok = ~(|(addr_q >> IDX_W));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |addr_q[ADDR_W-1:IDX_W];
  assign acc_ok         = 1'b1;
`endif

  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .byte_i  (byte_q),
    .idx_i   (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          byte_d  = byte_en;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!acc_ok) begin
          rdata_d = '0;
          fault_d = 1'b1;
        end else if (we_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = byte_q ? (mem_rd & DATA_W'(BYTE_MASK)) : mem_rd;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign ready = (state_q == RESP);
  assign rdata = rdata_q;
`ifdef MEM_FAULT_EN
  assign fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = fault_q;
  assign fault        = 1'b0;
`endif

endmodule
